// File: rtl/avalon_burst_arbiter.sv
// Round-robin arbiter that gives one Avalon-MM master at a time the shared slave for a whole burst.
// A grant is registered in IDLE and released on the edge of the burst's final accepted beat.
module avalon_burst_arbiter #(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned ADDR_WIDTH  = 30,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BURST_WIDTH = 8
) (
   input  logic                                  i_Clk,
   input  logic                                  i_Rst,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     i_AVIn_Addr,
   input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] i_AVIn_ByteEn,
   input  logic [NUM_MASTERS-1:0]                i_AVIn_Read,
   input  logic [NUM_MASTERS-1:0]                i_AVIn_Write,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     i_AVIn_WriteData,
   input  logic [NUM_MASTERS*BURST_WIDTH-1:0]    i_AVIn_BurstCount,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0]     o_AVIn_ReadData,
   output logic [NUM_MASTERS-1:0]                o_AVIn_WaitRequest,
   output logic [ADDR_WIDTH-1:0]                 o_AVOut_Addr,
   output logic [DATA_WIDTH/8-1:0]               o_AVOut_ByteEn,
   output logic                                  o_AVOut_Read,
   output logic                                  o_AVOut_Write,
   output logic [DATA_WIDTH-1:0]                 o_AVOut_WriteData,
   output logic [BURST_WIDTH-1:0]                o_AVOut_BurstCount,
   input  logic [DATA_WIDTH-1:0]                 i_AVOut_ReadData,
   input  logic                                  i_AVOut_WaitRequest,
   output logic [NUM_MASTERS-1:0]                o_Grant
);

   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
   localparam int unsigned PTR_WIDTH = $clog2(NUM_MASTERS);
   localparam logic [PTR_WIDTH:0] NumM = (PTR_WIDTH + 1)'(NUM_MASTERS);

   typedef enum logic {StIdle, StOwned} state_t;

   state_t                 state, nextState;
   logic [NUM_MASTERS-1:0] grant, nextGrant;
   logic [PTR_WIDTH-1:0]   owner, nextOwner;
   logic [PTR_WIDTH-1:0]   rrPtr, nextRrPtr;
   logic [BURST_WIDTH-1:0] burstLen, nextBurstLen;
   logic [BURST_WIDTH-1:0] beatCnt, nextBeatCnt;

   logic [ADDR_WIDTH-1:0]  addrArr  [NUM_MASTERS];
   logic [BE_WIDTH-1:0]    beArr    [NUM_MASTERS];
   logic [DATA_WIDTH-1:0]  wdArr    [NUM_MASTERS];
   logic [BURST_WIDTH-1:0] bcArr    [NUM_MASTERS];
   logic [NUM_MASTERS-1:0] req;

   logic                   found;
   logic [PTR_WIDTH-1:0]   winner;
   logic [PTR_WIDTH:0]     searchIdx;
   logic [PTR_WIDTH:0]     winnerNext;
   logic                   ownerReq;
   logic                   beat;

   always_comb begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
         addrArr[i] = i_AVIn_Addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         beArr[i]   = i_AVIn_ByteEn[i*BE_WIDTH +: BE_WIDTH];
         wdArr[i]   = i_AVIn_WriteData[i*DATA_WIDTH +: DATA_WIDTH];
         bcArr[i]   = i_AVIn_BurstCount[i*BURST_WIDTH +: BURST_WIDTH];
         req[i]     = i_AVIn_Read[i] | i_AVIn_Write[i];
      end
   end

   // Search starts at rrPtr and wraps; the first requester found wins.
   always_comb begin
      found     = 1'b0;
      winner    = '0;
      searchIdx = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         searchIdx = {1'b0, rrPtr} + (PTR_WIDTH + 1)'(k);
         if (searchIdx >= NumM) begin
            searchIdx = searchIdx - NumM;
         end
         if (!found && req[searchIdx[PTR_WIDTH-1:0]]) begin
            found  = 1'b1;
            winner = searchIdx[PTR_WIDTH-1:0];
         end
      end
      winnerNext = {1'b0, winner} + (PTR_WIDTH + 1)'(1);
      if (winnerNext == NumM) begin
         winnerNext = '0;
      end
   end

   assign ownerReq = i_AVIn_Read[owner] | i_AVIn_Write[owner];
   assign beat     = (state == StOwned) && ownerReq && !i_AVOut_WaitRequest;

   always_comb begin
      nextState    = state;
      nextGrant    = grant;
      nextOwner    = owner;
      nextRrPtr    = rrPtr;
      nextBurstLen = burstLen;
      nextBeatCnt  = beatCnt;
      unique case (state)
         StIdle: begin
            if (found) begin
               nextState    = StOwned;
               nextOwner    = winner;
               nextGrant    = NUM_MASTERS'(1) << winner;
               nextRrPtr    = winnerNext[PTR_WIDTH-1:0];
               nextBurstLen = (bcArr[winner] == '0) ? BURST_WIDTH'(1) : bcArr[winner];
               nextBeatCnt  = '0;
            end
         end
         StOwned: begin
            if (beat) begin
               if ((beatCnt + BURST_WIDTH'(1)) == burstLen) begin
                  nextState   = StIdle;
                  nextGrant   = '0;
                  nextBeatCnt = '0;
               end else begin
                  nextBeatCnt = beatCnt + BURST_WIDTH'(1);
               end
            end
         end
         default: begin
            nextState = StIdle;
            nextGrant = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state    <= StIdle;
         grant    <= '0;
         owner    <= '0;
         rrPtr    <= '0;
         burstLen <= '0;
         beatCnt  <= '0;
      end else begin
         state    <= nextState;
         grant    <= nextGrant;
         owner    <= nextOwner;
         rrPtr    <= nextRrPtr;
         burstLen <= nextBurstLen;
         beatCnt  <= nextBeatCnt;
      end
   end

   // Outputs follow the registered state only, so reset silences the slave port at once.
   always_comb begin
      o_AVOut_Addr       = '0;
      o_AVOut_ByteEn     = '0;
      o_AVOut_Read       = 1'b0;
      o_AVOut_Write      = 1'b0;
      o_AVOut_WriteData  = '0;
      o_AVOut_BurstCount = '0;
      o_AVIn_ReadData    = '0;
      o_AVIn_WaitRequest = '1;
      if (state == StOwned) begin
         o_AVOut_Addr       = addrArr[owner];
         o_AVOut_ByteEn     = beArr[owner];
         o_AVOut_Read       = i_AVIn_Read[owner];
         o_AVOut_Write      = i_AVIn_Write[owner];
         o_AVOut_WriteData  = wdArr[owner];
         o_AVOut_BurstCount = burstLen;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
               o_AVIn_ReadData[i*DATA_WIDTH +: DATA_WIDTH] = i_AVOut_ReadData;
               o_AVIn_WaitRequest[i]                       = i_AVOut_WaitRequest;
            end
         end
      end
   end

   assign o_Grant = grant;

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// Randomised rounds of contending bursts; expected slave beats are queued in service order
// and a negedge monitor pops and compares them as the arbiter forwards each accepted beat.
module tb_avalon_burst_arbiter;

   localparam int NM  = 4;
   localparam int AW  = 30;
   localparam int DW  = 32;
   localparam int BW  = 8;
   localparam int BEW = DW / 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NM*AW-1:0]  inAddr = '0;
   logic [NM*BEW-1:0] inBe = '0;
   logic [NM-1:0]     inRd = '0;
   logic [NM-1:0]     inWr = '0;
   logic [NM*DW-1:0]  inWd = '0;
   logic [NM*BW-1:0]  inBc = '0;
   logic [NM*DW-1:0]  outRdData;
   logic [NM-1:0]     outWait;
   logic [AW-1:0]     slvAddr;
   logic [BEW-1:0]    slvBe;
   logic              slvRd;
   logic              slvWr;
   logic [DW-1:0]     slvWd;
   logic [BW-1:0]     slvBc;
   logic [DW-1:0]     slvData = '0;
   logic              slvWait = 1'b0;
   logic [NM-1:0]     grant;

   avalon_burst_arbiter #(
      .NUM_MASTERS(NM),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .BURST_WIDTH(BW)
   ) dut (
      .i_Clk              (clk),
      .i_Rst              (rst),
      .i_AVIn_Addr        (inAddr),
      .i_AVIn_ByteEn      (inBe),
      .i_AVIn_Read        (inRd),
      .i_AVIn_Write       (inWr),
      .i_AVIn_WriteData   (inWd),
      .i_AVIn_BurstCount  (inBc),
      .o_AVIn_ReadData    (outRdData),
      .o_AVIn_WaitRequest (outWait),
      .o_AVOut_Addr       (slvAddr),
      .o_AVOut_ByteEn     (slvBe),
      .o_AVOut_Read       (slvRd),
      .o_AVOut_Write      (slvWr),
      .o_AVOut_WriteData  (slvWd),
      .o_AVOut_BurstCount (slvBc),
      .i_AVOut_ReadData   (slvData),
      .i_AVOut_WaitRequest(slvWait),
      .o_Grant            (grant)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            m;
      bit            rd;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BEW-1:0] be;
      logic [BW-1:0] bc;
   } beat_t;

   beat_t expQ[$];
   int    checks = 0;
   int    errors = 0;
   bit    monEn = 1'b0;
   int    ptr = 0;

   bit             active   [NM];
   bit             mRd      [NM];
   bit             mWr      [NM];
   int             beats    [NM];
   int             idx      [NM];
   int             pauseCnt [NM];
   bit             acc      [NM];
   logic [AW-1:0]  mAddr    [NM];
   logic [BEW-1:0] mBe      [NM];
   logic [BW-1:0]  mBc      [NM];
   logic [DW-1:0]  mData    [NM][8];

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic driveBus();
      bit on;
      for (int m = 0; m < NM; m++) begin
         on = active[m] && (pauseCnt[m] == 0);
         inRd[m] = on && mRd[m];
         inWr[m] = on && mWr[m];
         inAddr[m*AW +: AW]  = on ? mAddr[m] + AW'(idx[m]) : '0;
         inWd[m*DW +: DW]    = on ? mData[m][idx[m]] : '0;
         inBe[m*BEW +: BEW]  = on ? mBe[m] : '0;
         inBc[m*BW +: BW]    = on ? mBc[m] : '0;
      end
   endtask

   function automatic bit anyActive();
      bit a = 1'b0;
      for (int m = 0; m < NM; m++) a |= active[m];
      return a;
   endfunction

   // One clock: sample acceptances at negedge, advance masters and slave just after posedge.
   task automatic cycle(input int n, input int firstM);
      logic [NM-1:0] oh;
      @(negedge clk);
      oh = NM'(1) << firstM;
      if (n == 0) check("idle_before_grant", grant, '0);
      if (n == 1) check("grant_latency", grant, oh);
      for (int m = 0; m < NM; m++) acc[m] = (inRd[m] | inWr[m]) && !outWait[m];
      @(posedge clk);
      #1;
      for (int m = 0; m < NM; m++) begin
         if (active[m]) begin
            if (acc[m]) begin
               idx[m]++;
               if (idx[m] == beats[m]) active[m] = 1'b0;
               else if ($urandom_range(0, 5) == 0) pauseCnt[m] = $urandom_range(1, 4);
            end else if (pauseCnt[m] > 0) begin
               pauseCnt[m]--;
            end
         end
      end
      slvWait = ($urandom_range(0, 2) == 0);
      slvData = $urandom;
      driveBus();
   endtask

   initial begin : monitor
      beat_t             e;
      logic [NM-1:0]     prevGrant = '0;
      logic [NM-1:0]     oh;
      logic [NM*DW-1:0]  rdw;
      forever begin
         @(negedge clk);
         if (monEn) begin
            if (grant == '0) begin
               check("idle_outputs", {slvRd, slvWr, slvAddr, slvWd, slvBe, slvBc, outWait, outRdData},
                     {2'b00, AW'(0), DW'(0), BEW'(0), BW'(0), {NM{1'b1}}, (NM*DW)'(0)});
            end else begin
               if (prevGrant != '0) check("grant_held", grant, prevGrant);
               for (int m = 0; m < NM; m++) begin
                  if (grant[m]) check("owner_wait", outWait[m], slvWait);
                  else if (inRd[m] | inWr[m]) check("nonowner_wait", outWait[m], 1'b1);
               end
               if ((slvRd || slvWr) && !slvWait) begin
                  if (expQ.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_beat got grant=%0h want none at %0t", grant, $time);
                  end else begin
                     e   = expQ.pop_front();
                     oh  = NM'(1) << e.m;
                     rdw = '0;
                     rdw[e.m*DW +: DW] = slvData;
                     check("slave_beat", {grant, slvRd, slvWr, slvAddr, slvWd, slvBe, slvBc},
                           {oh, e.rd, e.wr, e.addr, e.data, e.be, e.bc});
                     check("read_data_route", outRdData, rdw);
                  end
               end
            end
            prevGrant = grant;
         end
      end
   end

   initial begin
      int    n;
      int    last;
      int    m;
      int    firstM;
      int    mask;
      int    mode;
      bit    allOne;
      beat_t e;

      for (int i = 0; i < NM; i++) begin
         active[i] = 1'b0;
         pauseCnt[i] = 0;
         idx[i] = 0;
      end
      #12;
      check("reset_grant", grant, '0);
      check("reset_wait", outWait, {NM{1'b1}});
      check("reset_slave", {slvRd, slvWr, slvAddr, slvWd, slvBe, slvBc, outRdData}, '0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      monEn = 1'b1;

      for (int r = 0; r < 40; r++) begin
         allOne = (r % 8 == 7);
         mask   = allOne ? 4'hF : $urandom_range(1, 15);
         for (int i = 0; i < NM; i++) begin
            if (mask[i]) begin
               mode      = allOne ? 1 : $urandom_range(0, 2);
               mRd[i]    = (mode != 1);
               mWr[i]    = (mode != 0);
               mBc[i]    = allOne ? BW'(1) : BW'($urandom_range(0, 5));
               beats[i]  = (mBc[i] == 0) ? 1 : int'(mBc[i]);
               mAddr[i]  = AW'($urandom);
               mBe[i]    = BEW'($urandom);
               for (int b = 0; b < 8; b++) mData[i][b] = $urandom;
               active[i] = 1'b1;
               idx[i]    = 0;
               pauseCnt[i] = 0;
            end
         end
         // Round-robin service order: every requester holds, so winners go cyclically from ptr.
         last = -1;
         firstM = -1;
         for (int k = 0; k < NM; k++) begin
            m = (ptr + k) % NM;
            if (mask[m]) begin
               if (firstM < 0) firstM = m;
               for (int b = 0; b < beats[m]; b++) begin
                  e.m = m; e.rd = mRd[m]; e.wr = mWr[m];
                  e.addr = mAddr[m] + AW'(b); e.data = mData[m][b];
                  e.be = mBe[m]; e.bc = (mBc[m] == 0) ? BW'(1) : mBc[m];
                  expQ.push_back(e);
               end
               last = m;
            end
         end
         ptr = (last + 1) % NM;
         driveBus();
         n = 0;
         while ((anyActive() || expQ.size() != 0) && n < 400) begin
            cycle(n, firstM);
            n++;
         end
         if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL round_timeout got pending=%0d want 0 in round %0d", expQ.size(), r);
            expQ.delete();
            for (int i = 0; i < NM; i++) active[i] = 1'b0;
            driveBus();
            rst = 1'b1;
            #3;
            rst = 1'b0;
            ptr = 0;
            @(posedge clk);
            #1;
         end
      end

      // Reset in the middle of a 4-beat write from M0.
      monEn = 1'b0;
      slvWait = 1'b0;
      mRd[0] = 1'b0; mWr[0] = 1'b1; mBc[0] = BW'(4); beats[0] = 4;
      mAddr[0] = AW'(32'h100); mBe[0] = '1;
      for (int b = 0; b < 8; b++) mData[0][b] = DW'(b + 1);
      active[0] = 1'b1; idx[0] = 0; pauseCnt[0] = 0;
      driveBus();
      n = 0;
      while (idx[0] < 2 && n < 50) begin
         @(negedge clk);
         for (int i = 0; i < NM; i++) acc[i] = (inRd[i] | inWr[i]) && !outWait[i];
         @(posedge clk);
         #1;
         if (acc[0]) idx[0]++;
         driveBus();
         n++;
      end
      check("beats_before_reset", idx[0], 2);
      #2;
      rst = 1'b1;
      #1;
      check("reset_abort_write", slvWr, 1'b0);
      check("reset_abort_grant", grant, '0);
      check("reset_abort_wait", outWait, {NM{1'b1}});
      @(negedge clk);
      rst = 1'b0;
      mRd[1] = 1'b0; mWr[1] = 1'b1; mBc[1] = BW'(1); beats[1] = 1;
      mAddr[1] = AW'(32'h200); mBe[1] = '1; mData[1][0] = DW'(32'hA);
      active[1] = 1'b1; idx[1] = 0; pauseCnt[1] = 0;
      idx[0] = 0;
      driveBus();
      @(posedge clk);
      @(negedge clk);
      check("ptr_after_reset", grant, NM'(1));
      check("burst_restart_data", slvWd, DW'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/avalon_burst_arbiter.md
AVALON_BURST_ARBITER -- requirements
Module: avalon_burst_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting master ports (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 30, word address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width; ByteEn width is DATA_WIDTH/8.
REQ-004 SHALL have parameter BURST_WIDTH, default 8, burst count width.
REQ-005 SHALL have port i_Clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_Rst  in  1  reset; asynchronous and active-high.
REQ-007 SHALL have ports i_AVIn_Addr, i_AVIn_ByteEn, i_AVIn_Read, i_AVIn_Write, i_AVIn_WriteData, i_AVIn_BurstCount  in  NUM_MASTERS x field width  master request buses, packed with master 0 in the LSBs.
REQ-008 SHALL have ports o_AVIn_ReadData  out  NUM_MASTERS x DATA_WIDTH  and o_AVIn_WaitRequest  out  NUM_MASTERS  per-master responses, same packing.
REQ-009 SHALL have ports o_AVOut_Addr, o_AVOut_ByteEn, o_AVOut_Read, o_AVOut_Write, o_AVOut_WriteData, o_AVOut_BurstCount  out  field width  shared slave port.
REQ-010 SHALL have ports i_AVOut_ReadData  in  DATA_WIDTH  and i_AVOut_WaitRequest  in  1  slave responses.
REQ-011 SHALL have port o_Grant  out  NUM_MASTERS  one-hot current owner; all zero when idle.

Function
REQ-012 SHALL implement two states: IDLE (no owner) and OWNED (one master holds the slave for a burst).
REQ-013 A master requests when its Read or Write is high; in IDLE the arbiter SHALL sample requests and register a grant, so the first beat reaches the slave one cycle after the request is first seen.
REQ-014 Arbitration SHALL be round-robin: search starts at the master after the last owner (master 0 after reset); ties are resolved by that order only.
REQ-015 On grant, BurstCount of the winner SHALL be latched; value 0 SHALL be treated as 1.
REQ-016 In OWNED, slave outputs SHALL combinationally mirror the owner's Addr, ByteEn, Read, Write, WriteData and the latched BurstCount.
REQ-017 A beat SHALL be counted when the owner's Read or Write is high and i_AVOut_WaitRequest is low; the beat counter SHALL increment by 1 per beat.
REQ-018 The grant SHALL release to IDLE on the clock edge of the final beat (count = latched BurstCount); a new grant needs one further IDLE cycle.
REQ-019 The owner deasserting Read/Write mid-burst SHALL NOT release the grant; the burst resumes when the owner reasserts.
REQ-020 The owner's WaitRequest SHALL equal i_AVOut_WaitRequest; every non-owner's WaitRequest SHALL be 1 whenever its Read or Write is high, and 1 in IDLE.
REQ-021 The owner's ReadData SHALL equal i_AVOut_ReadData; non-owners' ReadData SHALL be 0.
REQ-022 In IDLE, o_AVOut_Read and o_AVOut_Write SHALL be 0; Addr, ByteEn, WriteData, BurstCount SHALL be 0.
REQ-023 A master asserting both Read and Write SHALL be granted as a write; Read is still forwarded unchanged.

Reset
REQ-024 While i_Rst is high, state SHALL be IDLE, o_Grant 0, beat counter 0, round-robin pointer to master 0, all o_AVIn_WaitRequest 1 and all other outputs 0.
REQ-025 Reset asserted mid-burst SHALL abort the burst immediately (asynchronously) with no further slave beats.
REQ-026 After reset deassertion, the first request SHALL be arbitrated on the first rising edge it is sampled.

Verification
REQ-027 M0 write burst BurstCount=4, data 1..4, slave WaitRequest 1 cycle/beat -> slave sees 4 writes in order, o_Grant=0001 throughout, returns to 0 after beat 4.
REQ-028 M0 burst of 4 and M1 single write (BurstCount=1, data 0xA) requested in the same cycle -> M0 served fully first, M1 WaitRequest held 1, M1 granted after one IDLE cycle.
REQ-029 M0 drops Write after beat 2 for 4 cycles, then resumes -> grant stays 0001, M2 request in the gap sees WaitRequest 1, burst completes with 4 beats.
REQ-030 All four masters request continuously with BurstCount=1 -> grants rotate 0001, 0010, 0100, 1000, 0001.
REQ-031 M1 read burst BurstCount=0 -> treated as 1 beat; M1 ReadData equals slave ReadData, other masters' ReadData 0.
REQ-032 i_Rst pulsed after beat 2 of a 4-beat write -> o_AVOut_Write 0 immediately, o_Grant 0, pointer reset so M0 wins the next contention.
